// File: rtl/osd_u8g2_tx_if.sv
// Writer-side and link-side signals of the u8g2 OSD byte transmitter.
// The slave modport is the transmitter; the master modport is the writer and link observer.
interface osd_u8g2_tx_if;
   logic       wr_en;
   logic [9:0] wr_addr;
   logic [7:0] wr_data;
   logic       show_req;
   logic       show_val;
   logic       flush;
   logic       busy;
   logic       tx_strobe;
   logic       tx_start;
   logic [7:0] tx_data;

   modport master (
      output wr_en, wr_addr, wr_data, show_req, show_val, flush,
      input  busy, tx_strobe, tx_start, tx_data
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, show_req, show_val, flush,
      output busy, tx_strobe, tx_start, tx_data
   );
endinterface

// File: rtl/osd_u8g2_tx.sv
// u8g2 OSD transmitter: 1 KB page-organised shadow RAM, dirty-tile tracking and framed serialiser.
// Optional OSD_TX_SKIP_UNCHANGED_EN: two-stage write that dirties a tile only when the byte changes.
module osd_u8g2_tx #(
   parameter int GAP = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   osd_u8g2_tx_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ARG, S_DATA, S_TAIL} state_t;

   state_t       state_reg;
   logic [7:0]   cnt_reg;
   logic [6:0]   ptr_reg;
   logic [6:0]   tile_reg;
   logic [2:0]   k_reg;
   logic         is_show_reg;
   logic         frame_val_reg;
   logic         pend_reg;
   logic         pend_val_reg;
   logic [127:0] dirty_reg;
   logic         strobe_reg;
   logic         start_reg;
   logic [7:0]   data_reg;

   logic [7:0]   mem [0:1023];
   logic [7:0]   rd_data;

   logic         mem_we;
   logic [9:0]   mem_waddr;
   logic [7:0]   mem_wdata;
   logic         set_en;
   logic [6:0]   set_tile;
   logic [127:0] set_vec;
   logic [127:0] clr_vec;

   logic emit_arg_tile;
   logic emit_cmd_show;
   logic rd_en;

   assign emit_arg_tile = (state_reg == S_CMD) && (cnt_reg == 8'd0) && !is_show_reg;
   assign emit_cmd_show = (state_reg == S_IDLE) && pend_reg;
   // Fetch the next data byte on the first gap clock after a strobe.
   assign rd_en = ((state_reg == S_ARG) || (state_reg == S_DATA)) && (cnt_reg == 8'(GAP - 1));

`ifdef OSD_TX_SKIP_UNCHANGED_EN
   logic       s2_valid_reg;
   logic [9:0] s2_addr_reg;
   logic [7:0] s2_data_reg;
   logic [7:0] old_reg;
   logic       fwd_reg;
   logic [7:0] fwd_data_reg;
   logic [7:0] old_byte;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) s2_valid_reg <= 1'b0;
      else          s2_valid_reg <= bus.wr_en;
   end

   // A write landing this clock is not yet visible to the old-byte read, so forward it.
   always_ff @(posedge clk) begin
      s2_addr_reg  <= bus.wr_addr;
      s2_data_reg  <= bus.wr_data;
      old_reg      <= mem[bus.wr_addr];
      fwd_reg      <= s2_valid_reg && (s2_addr_reg == bus.wr_addr);
      fwd_data_reg <= s2_data_reg;
   end

   assign old_byte  = fwd_reg ? fwd_data_reg : old_reg;
   assign mem_we    = s2_valid_reg;
   assign mem_waddr = s2_addr_reg;
   assign mem_wdata = s2_data_reg;
   assign set_en    = s2_valid_reg && (s2_data_reg != old_byte);
   assign set_tile  = s2_addr_reg[9:3];
`else
   assign mem_we    = bus.wr_en;
   assign mem_waddr = bus.wr_addr;
   assign mem_wdata = bus.wr_data;
   assign set_en    = bus.wr_en;
   assign set_tile  = bus.wr_addr[9:3];
`endif

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (rd_en)  rd_data <= mem[{tile_reg, k_reg}];
   end

   genvar gi;
   generate
      for (gi = 0; gi < 128; gi++) begin : g_dirty
         assign set_vec[gi] = bus.flush || (set_en && (set_tile == 7'(gi)));
         assign clr_vec[gi] = emit_arg_tile && (tile_reg == 7'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dirty_reg <= '0;
      else          dirty_reg <= (dirty_reg & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= 8'd0;
         ptr_reg       <= 7'd0;
         tile_reg      <= 7'd0;
         k_reg         <= 3'd0;
         is_show_reg   <= 1'b0;
         frame_val_reg <= 1'b0;
         pend_reg      <= 1'b0;
         pend_val_reg  <= 1'b0;
         strobe_reg    <= 1'b0;
         start_reg     <= 1'b0;
         data_reg      <= 8'd0;
      end else begin
         strobe_reg <= 1'b0;
         // A new request wins over the clear caused by sending the previous one.
         if (bus.show_req) begin
            pend_reg     <= 1'b1;
            pend_val_reg <= bus.show_val;
         end else if (emit_cmd_show) begin
            pend_reg <= 1'b0;
         end

         case (state_reg)
            S_IDLE: begin
               if (pend_reg) begin
                  strobe_reg    <= 1'b1;
                  start_reg     <= 1'b1;
                  data_reg      <= 8'h01;
                  is_show_reg   <= 1'b1;
                  frame_val_reg <= pend_val_reg;
                  cnt_reg       <= 8'(GAP - 1);
                  state_reg     <= S_CMD;
               end else if (dirty_reg[ptr_reg]) begin
                  strobe_reg  <= 1'b1;
                  start_reg   <= 1'b1;
                  data_reg    <= 8'h02;
                  is_show_reg <= 1'b0;
                  tile_reg    <= ptr_reg;
                  k_reg       <= 3'd0;
                  cnt_reg     <= 8'(GAP - 1);
                  state_reg   <= S_CMD;
               end else begin
                  ptr_reg <= ptr_reg + 7'd1;
               end
            end
            S_CMD: begin
               if (cnt_reg == 8'd0) begin
                  strobe_reg <= 1'b1;
                  start_reg  <= 1'b0;
                  if (is_show_reg) begin
                     data_reg  <= {7'b0, frame_val_reg};
                     cnt_reg   <= 8'(GAP - 2);
                     state_reg <= S_TAIL;
                  end else begin
                     data_reg  <= {1'b0, tile_reg};
                     cnt_reg   <= 8'(GAP - 1);
                     state_reg <= S_ARG;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_ARG, S_DATA: begin
               if (cnt_reg == 8'd0) begin
                  strobe_reg <= 1'b1;
                  start_reg  <= 1'b0;
                  data_reg   <= rd_data;
                  k_reg      <= k_reg + 3'd1;
                  if (k_reg == 3'd7) begin
                     cnt_reg   <= 8'(GAP - 2);
                     state_reg <= S_TAIL;
                  end else begin
                     cnt_reg   <= 8'(GAP - 1);
                     state_reg <= S_DATA;
                  end
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            S_TAIL: begin
               // Leaving one clock early keeps the next frame's strobe exactly GAP away.
               if (cnt_reg == 8'd0) begin
                  state_reg <= S_IDLE;
                  if (!is_show_reg) ptr_reg <= tile_reg + 7'd1;
               end else begin
                  cnt_reg <= cnt_reg - 8'd1;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign bus.tx_strobe = strobe_reg;
   assign bus.tx_start  = start_reg;
   assign bus.tx_data   = data_reg;
   assign bus.busy      = (state_reg != S_IDLE) || pend_reg || (|dirty_reg);

endmodule

// File: tb/tb_osd_u8g2_tx.sv
// Scoreboard bench for osd_u8g2_tx: expected link bytes are queued as stimulus is driven
// and checked by a strobe monitor, together with intra-frame strobe spacing.
module tb_osd_u8g2_tx;
   localparam int GAP = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   osd_u8g2_tx_if bus ();

   osd_u8g2_tx #(.GAP(GAP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int         checks = 0;
   int         failures = 0;
   logic [8:0] exp_q[$];
   logic [8:0] exp_e;
   logic [7:0] model [0:1023];
   bit         sb_on = 1'b0;
   int         strobe_cnt = 0;
   longint     cyc = 0;
   longint     last_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.tx_strobe === 1'b1) begin
         strobe_cnt++;
         if (sb_on) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected got=%b_%h required=none", bus.tx_start, bus.tx_data);
            end else begin
               exp_e = exp_q.pop_front();
               if ({bus.tx_start, bus.tx_data} !== exp_e)
                  begin failures++; $display("FAIL sb_byte got=%b_%h required=%b_%h", bus.tx_start, bus.tx_data, exp_e[8], exp_e[7:0]); end
               else
                  $display("strobe start=%b data=%h ok", bus.tx_start, bus.tx_data);
            end
            if (bus.tx_start === 1'b0) begin
               checks++;
               if (cyc - last_cyc != GAP) begin
                  failures++;
                  $display("FAIL strobe_spacing got=%0d required=%0d", cyc - last_cyc, GAP);
               end
            end
         end
         last_cyc = cyc;
      end
   end

   task automatic wr(input logic [9:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      model[a] = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic push_tile(input logic [6:0] t);
      logic [9:0] a;
      exp_q.push_back({1'b1, 8'h02});
      exp_q.push_back({1'b0, 1'b0, t});
      for (int k = 0; k < 8; k++) begin
         a = {t, 3'(k)};
         exp_q.push_back({1'b0, model[a]});
      end
   endtask

   task automatic push_show(input logic v);
      exp_q.push_back({1'b1, 8'h01});
      exp_q.push_back({1'b0, 7'b0, v});
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < budget; i++) begin
         if (bus.busy === 1'b0 && exp_q.size() == 0) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic wait_strobes(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (strobe_cnt >= n) begin ok = 1'b1; break; end
         @(negedge clk);
      end
   endtask

   task automatic test_preload;
      bit ok;
      sb_on = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         bus.wr_en = 1'b1; bus.wr_addr = 10'(i); bus.wr_data = 8'((i * 13) ^ (i >> 2));
         model[i] = 8'((i * 13) ^ (i >> 2));
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      wait_idle(30000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL preload_drain got=busy required=idle"); end
   endtask

   task automatic test_reset;
      bit ok;
      int base;
      sb_on = 1'b0;
      base = strobe_cnt;
      wr(10'h0A3, 8'h3E);
      wait_strobes(base + 3, 2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL abort_frame_start got=%0d required=%0d", strobe_cnt - base, 3); end
      reset_n = 1'b0;
      @(negedge clk);
      checks += 4;
      if (bus.tx_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b required=0", bus.tx_strobe); end
      if (bus.tx_start !== 1'b0)  begin failures++; $display("FAIL reset_start got=%b required=0", bus.tx_start); end
      if (bus.tx_data !== 8'h00)  begin failures++; $display("FAIL reset_data got=%h required=00", bus.tx_data); end
      if (bus.busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b required=0", bus.busy); end
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      base = strobe_cnt;
      repeat (60) @(negedge clk);
      checks += 2;
      if (strobe_cnt != base) begin failures++; $display("FAIL abort_no_resume got=%0d required=0", strobe_cnt - base); end
      if (bus.busy !== 1'b0)  begin failures++; $display("FAIL post_reset_busy got=%b required=0", bus.busy); end
      $display("reset checked");
   endtask

   task automatic test_flush;
      bit ok;
      int base;
      sb_on = 1'b1;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      // The scan pointer steps once per idle clock; flush lands when it wraps back to 0.
      repeat (127) @(negedge clk);
      for (int t = 0; t < 128; t++) push_tile(7'(t));
      base = strobe_cnt;
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      wait_idle(20000, ok);
      checks += 2;
      if (!ok) begin failures++; $display("FAIL flush_drain got=left_%0d required=0", exp_q.size()); end
      if (strobe_cnt - base != 1280) begin failures++; $display("FAIL flush_count got=%0d required=1280", strobe_cnt - base); end
      $display("flush strobes=%0d", strobe_cnt - base);
   endtask

   task automatic test_show;
      bit ok;
      @(negedge clk);
      bus.show_req = 1'b1; bus.show_val = 1'b1;
      push_show(1'b1);
      @(negedge clk);
      bus.show_req = 1'b0;
      checks++;
      if (bus.busy !== 1'b1) begin failures++; $display("FAIL show_busy got=%b required=1", bus.busy); end
      wait_idle(200, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL show_done got=busy_%b required=0", bus.busy); end
      $display("show frame done");
   endtask

   task automatic test_single_write;
      bit ok;
      wr(10'h3FF, 8'hA5);
      push_tile(7'd127);
      wait_idle(2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL tile127_done got=left_%0d required=0", exp_q.size()); end
      $display("tile 127 frame done");
   endtask

   task automatic test_rewrite_midframe;
      bit ok;
      int base;
      base = strobe_cnt;
      wr(10'd41, 8'h5A);
      push_tile(7'd5);
      wait_strobes(base + 6, 2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midframe_reach got=%0d required=6", strobe_cnt - base); end
      wr(10'd41, 8'hC3);
      push_tile(7'd5);
      wait_idle(3000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL resend_done got=left_%0d required=0", exp_q.size()); end
      $display("tile 5 resend done");
   endtask

   task automatic test_show_priority;
      bit ok;
      int base;
      base = strobe_cnt;
      wr(10'd26, 8'h77);
      push_tile(7'd3);
      wait_strobes(base + 2, 2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL prio_reach got=%0d required=2", strobe_cnt - base); end
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 10'd72; bus.wr_data = 8'h99;
      model[72] = 8'h99;
      bus.show_req = 1'b1; bus.show_val = 1'b0;
      @(negedge clk);
      bus.wr_en = 1'b0;
      bus.show_val = 1'b1;
      @(negedge clk);
      bus.show_req = 1'b0;
      push_show(1'b1);
      push_tile(7'd9);
      wait_idle(3000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL prio_done got=left_%0d required=0", exp_q.size()); end
      $display("priority sequence done");
   endtask

   task automatic test_repeat_write;
      bit ok;
      int base;
      logic [7:0] v;
      v = model[16] ^ 8'hFF;
      wr(10'h010, v);
      push_tile(7'd2);
      wait_idle(2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL repeat_first got=left_%0d required=0", exp_q.size()); end
      base = strobe_cnt;
      wr(10'h010, v);
      v = model[17];
      wr(10'h011, v);
`ifndef OSD_TX_SKIP_UNCHANGED_EN
      push_tile(7'd2);
`endif
      wait_idle(2000, ok);
      checks += 2;
      if (!ok) begin failures++; $display("FAIL repeat_second got=left_%0d required=0", exp_q.size()); end
`ifdef OSD_TX_SKIP_UNCHANGED_EN
      if (strobe_cnt - base != 0)  begin failures++; $display("FAIL repeat_count got=%0d required=0", strobe_cnt - base); end
`else
      if (strobe_cnt - base != 10) begin failures++; $display("FAIL repeat_count got=%0d required=10", strobe_cnt - base); end
`endif
      $display("repeat write strobes=%0d", strobe_cnt - base);
   endtask

   task automatic test_back_to_back;
      bit ok;
      logic [7:0] old;
      old = model[10'h020];
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = 10'h020; bus.wr_data = old ^ 8'h55;
      @(negedge clk);
      bus.wr_data = old;
      @(negedge clk);
      bus.wr_en = 1'b0;
      push_tile(7'd4);
      wait_idle(2000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_done got=left_%0d required=0", exp_q.size()); end
      $display("back-to-back write done");
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.show_req = 1'b0; bus.show_val = 1'b0; bus.flush = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      test_preload();
      test_reset();
      test_flush();
      test_show();
      test_single_write();
      test_rewrite_midframe();
      test_show_priority();
      test_repeat_write();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
